// File: rtl/sipo_fifo_axi4lite.sv
// Serial-in/parallel-out deserialiser feeding a DEPTH-entry word FIFO, with an
// AXI4-Lite register port for data pops, status, control, level and threshold.
`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 32
`endif
`ifndef AXI4_STRB_BITS
`define AXI4_STRB_BITS 4
`endif
`ifndef AXI4_PROT_BITS
`define AXI4_PROT_BITS 3
`endif
`ifndef AXI4_RESP_BITS
`define AXI4_RESP_BITS 2
`endif

module sipo_fifo_axi4lite #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        s_axi4lite_clk,
  input  logic                        s_axi4lite_rstn,
  input  logic                        sin,
  input  logic                        sin_valid,
  output logic                        irq,
  input  logic                        s_axi4lite_aw_valid,
  output logic                        s_axi4lite_aw_ready,
  input  logic [`AXI4_ADDR_BITS-1:0]  s_axi4lite_aw_addr,
  input  logic [`AXI4_PROT_BITS-1:0]  s_axi4lite_aw_prot,
  input  logic                        s_axi4lite_w_valid,
  output logic                        s_axi4lite_w_ready,
  input  logic [`AXI4_DATA_BITS-1:0]  s_axi4lite_w_data,
  input  logic [`AXI4_STRB_BITS-1:0]  s_axi4lite_w_strb,
  output logic                        s_axi4lite_b_valid,
  input  logic                        s_axi4lite_b_ready,
  output logic [`AXI4_RESP_BITS-1:0]  s_axi4lite_b_resp,
  input  logic                        s_axi4lite_ar_valid,
  output logic                        s_axi4lite_ar_ready,
  input  logic [`AXI4_ADDR_BITS-1:0]  s_axi4lite_ar_addr,
  input  logic [`AXI4_PROT_BITS-1:0]  s_axi4lite_ar_prot,
  output logic                        s_axi4lite_r_valid,
  input  logic                        s_axi4lite_r_ready,
  output logic [`AXI4_DATA_BITS-1:0]  s_axi4lite_r_data,
  output logic [`AXI4_RESP_BITS-1:0]  s_axi4lite_r_resp
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(DATA_W);
  localparam int AD = `AXI4_DATA_BITS;
  localparam int RW = `AXI4_RESP_BITS;

  localparam logic [7:0] A_DATA   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h08;
  localparam logic [7:0] A_CTRL   = 8'h10;
  localparam logic [7:0] A_LEVEL  = 8'h18;
  localparam logic [7:0] A_THRESH = 8'h20;
  localparam logic [RW-1:0] OKAY   = RW'(0);
  localparam logic [RW-1:0] SLVERR = RW'(2);

  logic              clk, rst_n;
  logic [DATA_W-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d, thresh_q, thresh_d;
  logic              ovf_q, ovf_d, en_q, en_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [7:0]        awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [AD-1:0]     wdata_q, wdata_d;
  logic              wstrb0_q, wstrb0_d;
  logic              b_valid_q, b_valid_d, rd_req_q, rd_req_d, r_valid_q, r_valid_d;
  logic [RW-1:0]     b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic [AD-1:0]     r_data_q, r_data_d;

  logic aw_hs, w_hs, ar_hs, wr_fire, wr_map, ctrl_wr, thresh_wr, flush, ovf_clr;
  logic shift, word_done, push_try, push, pop, full, empty;
  logic unused_bits;

  assign clk   = s_axi4lite_clk;
  assign rst_n = s_axi4lite_rstn;
  assign unused_bits = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot, s_axi4lite_aw_addr,
                         s_axi4lite_ar_addr, s_axi4lite_w_strb};

  assign s_axi4lite_aw_ready = !aw_held_q && !b_valid_q;
  assign s_axi4lite_w_ready  = !w_held_q && !b_valid_q;
  assign s_axi4lite_ar_ready = !rd_req_q && !r_valid_q;
  assign s_axi4lite_b_valid  = b_valid_q;
  assign s_axi4lite_b_resp   = b_resp_q;
  assign s_axi4lite_r_valid  = r_valid_q;
  assign s_axi4lite_r_data   = r_data_q;
  assign s_axi4lite_r_resp   = r_resp_q;
  assign irq                 = irq_q;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // Write channel: the register write lands on the same edge b_valid rises.
  always_comb begin
    aw_hs     = s_axi4lite_aw_valid && s_axi4lite_aw_ready;
    w_hs      = s_axi4lite_w_valid && s_axi4lite_w_ready;
    wr_fire   = aw_held_q && w_held_q;
    aw_held_d = wr_fire ? 1'b0 : (aw_hs ? 1'b1 : aw_held_q);
    w_held_d  = wr_fire ? 1'b0 : (w_hs ? 1'b1 : w_held_q);
    awaddr_d  = aw_hs ? s_axi4lite_aw_addr[7:0] : awaddr_q;
    wdata_d   = w_hs ? s_axi4lite_w_data : wdata_q;
    wstrb0_d  = w_hs ? s_axi4lite_w_strb[0] : wstrb0_q;
    wr_map    = (awaddr_q == A_DATA) || (awaddr_q == A_STATUS) || (awaddr_q == A_CTRL) ||
                (awaddr_q == A_LEVEL) || (awaddr_q == A_THRESH);
    b_valid_d = wr_fire ? 1'b1 : (b_valid_q && !s_axi4lite_b_ready);
    b_resp_d  = wr_fire ? (wr_map ? OKAY : SLVERR) : b_resp_q;
    ctrl_wr   = wr_fire && wstrb0_q && (awaddr_q == A_CTRL);
    thresh_wr = wr_fire && wstrb0_q && (awaddr_q == A_THRESH);
    flush     = ctrl_wr && wdata_q[1];
    ovf_clr   = ctrl_wr && wdata_q[2];
    en_d      = ctrl_wr ? wdata_q[0] : en_q;
    irq_en_d  = ctrl_wr ? wdata_q[3] : irq_en_q;
    thresh_d  = thresh_q;
    if (thresh_wr)
      thresh_d = (wdata_q > AD'(DEPTH)) ? LW'(DEPTH) : wdata_q[LW-1:0];
  end

  // Read channel: pop and response capture happen the edge after the AR handshake.
  always_comb begin
    ar_hs     = s_axi4lite_ar_valid && s_axi4lite_ar_ready;
    rd_req_d  = ar_hs;
    araddr_d  = ar_hs ? s_axi4lite_ar_addr[7:0] : araddr_q;
    r_valid_d = rd_req_q ? 1'b1 : (r_valid_q && !s_axi4lite_r_ready);
    pop       = rd_req_q && (araddr_q == A_DATA) && !empty;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    if (rd_req_q) begin
      r_resp_d = OKAY;
      case (araddr_q)
        A_DATA:   r_data_d = empty ? '0 : AD'(mem_q[rptr_q]);
        A_STATUS: r_data_d = AD'({irq_q, ovf_q, full, empty});
        A_CTRL:   r_data_d = AD'({irq_en_q, 2'b00, en_q});
        A_LEVEL:  r_data_d = AD'(level_q);
        A_THRESH: r_data_d = AD'(thresh_q);
        default: begin
          r_data_d = '0;
          r_resp_d = SLVERR;
        end
      endcase
    end
  end

  // Deserialiser and FIFO bookkeeping; a flush overrides any word completing now.
  always_comb begin
    shift     = en_q && sin_valid;
    sr_shift  = MSB_FIRST ? {sr_q[DATA_W-2:0], sin} : {sin, sr_q[DATA_W-1:1]};
    word_done = shift && (bit_cnt_q == CW'(DATA_W - 1));
    push_try  = word_done && !flush;
    push      = push_try && (!full || pop);
    sr_d      = flush ? '0 : (shift ? sr_shift : sr_q);
    bit_cnt_d = bit_cnt_q;
    if (flush || word_done)
      bit_cnt_d = '0;
    else if (shift)
      bit_cnt_d = bit_cnt_q + CW'(1);
    ovf_d   = ovf_clr ? 1'b0 : ((push_try && !push) ? 1'b1 : ovf_q);
    wptr_d  = flush ? '0 : (push ? wptr_q + PW'(1) : wptr_q);
    rptr_d  = flush ? '0 : (pop ? rptr_q + PW'(1) : rptr_q);
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
    irq_d   = irq_en_q && (thresh_q != '0) && (level_q >= thresh_q);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= sr_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      thresh_q  <= LW'(1);
      ovf_q     <= 1'b0;
      en_q      <= 1'b1;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb0_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_resp_q  <= '0;
      rd_req_q  <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      thresh_q  <= thresh_d;
      ovf_q     <= ovf_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb0_q  <= wstrb0_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      rd_req_q  <= rd_req_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

endmodule

// File: tb/tb_sipo_fifo_axi4lite.sv
// Bench: two 8-bit/4-deep instances (MSB-first and LSB-first) driven in lockstep,
// checked against a queue-based model of the serial stream and FIFO.
module tb_sipo_fifo_axi4lite;

  logic        clk = 1'b0;
  logic        rstn, sin, sin_valid;
  logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic [31:0] aw_addr, w_data, ar_addr;
  logic [2:0]  aw_prot, ar_prot;
  logic [3:0]  w_strb;
  logic        irq_a, aw_ready_a, w_ready_a, b_valid_a, ar_ready_a, r_valid_a;
  logic        irq_b, aw_ready_b, w_ready_b, b_valid_b, ar_ready_b, r_valid_b;
  logic [1:0]  b_resp_a, r_resp_a, b_resp_b, r_resp_b;
  logic [31:0] r_data_a, r_data_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       bits[8];
  int         nb = 0;
  bit         mdl_en = 1'b1;

  always #5 clk = ~clk;

  sipo_fifo_axi4lite #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut_a (
    .s_axi4lite_clk(clk), .s_axi4lite_rstn(rstn), .sin(sin), .sin_valid(sin_valid), .irq(irq_a),
    .s_axi4lite_aw_valid(aw_valid), .s_axi4lite_aw_ready(aw_ready_a), .s_axi4lite_aw_addr(aw_addr),
    .s_axi4lite_aw_prot(aw_prot), .s_axi4lite_w_valid(w_valid), .s_axi4lite_w_ready(w_ready_a),
    .s_axi4lite_w_data(w_data), .s_axi4lite_w_strb(w_strb), .s_axi4lite_b_valid(b_valid_a),
    .s_axi4lite_b_ready(b_ready), .s_axi4lite_b_resp(b_resp_a), .s_axi4lite_ar_valid(ar_valid),
    .s_axi4lite_ar_ready(ar_ready_a), .s_axi4lite_ar_addr(ar_addr), .s_axi4lite_ar_prot(ar_prot),
    .s_axi4lite_r_valid(r_valid_a), .s_axi4lite_r_ready(r_ready), .s_axi4lite_r_data(r_data_a),
    .s_axi4lite_r_resp(r_resp_a));

  sipo_fifo_axi4lite #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_b (
    .s_axi4lite_clk(clk), .s_axi4lite_rstn(rstn), .sin(sin), .sin_valid(sin_valid), .irq(irq_b),
    .s_axi4lite_aw_valid(aw_valid), .s_axi4lite_aw_ready(aw_ready_b), .s_axi4lite_aw_addr(aw_addr),
    .s_axi4lite_aw_prot(aw_prot), .s_axi4lite_w_valid(w_valid), .s_axi4lite_w_ready(w_ready_b),
    .s_axi4lite_w_data(w_data), .s_axi4lite_w_strb(w_strb), .s_axi4lite_b_valid(b_valid_b),
    .s_axi4lite_b_ready(b_ready), .s_axi4lite_b_resp(b_resp_b), .s_axi4lite_ar_valid(ar_valid),
    .s_axi4lite_ar_ready(ar_ready_b), .s_axi4lite_ar_addr(ar_addr), .s_axi4lite_ar_prot(ar_prot),
    .s_axi4lite_r_valid(r_valid_b), .s_axi4lite_r_ready(r_ready), .s_axi4lite_r_data(r_data_b),
    .s_axi4lite_r_resp(r_resp_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: bits in arrival order; MSB-first places bit i at 7-i, LSB-first at i.
  task automatic mdl_bit(input logic b);
    logic [7:0] wa, wb;
    if (!mdl_en) return;
    bits[nb] = b;
    nb++;
    if (nb == 8) begin
      wa = '0;
      wb = '0;
      for (int i = 0; i < 8; i++) begin
        wa[7-i] = bits[i];
        wb[i]   = bits[i];
      end
      nb = 0;
      if (qa.size() < 4) begin
        qa.push_back(wa);
        qb.push_back(wb);
      end
    end
  endtask

  task automatic mdl_reset();
    qa.delete();
    qb.delete();
    nb = 0;
    mdl_en = 1'b1;
  endtask

  // Sends the top n bits of v, most significant first; sin_valid is left high.
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sin = v[7-i];
      sin_valid = 1'b1;
      mdl_bit(v[7-i]);
    end
  endtask

  task automatic stop_bits();
    @(negedge clk);
    sin_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] da, output logic [31:0] db,
                    output logic [1:0] resp);
    int n;
    @(negedge clk);
    sin_valid = 1'b0;
    ar_valid = 1'b1;
    ar_addr = {24'h0, addr};
    n = 0;
    while (!ar_ready_a && n < 20) begin @(negedge clk); n++; end
    if (!ar_ready_a) chk("ar_ready_timeout", ar_ready_a, 1);
    @(negedge clk);
    ar_valid = 1'b0;
    r_ready = 1'b1;
    n = 0;
    while (!r_valid_a && n < 20) begin @(negedge clk); n++; end
    if (!r_valid_a) chk("r_valid_timeout", r_valid_a, 1);
    da = r_data_a;
    db = r_data_b;
    resp = r_resp_a;
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp,
                        input logic [1:0] exp_resp);
    logic [31:0] da, db;
    logic [1:0]  resp;
    rd(addr, da, db, resp);
    chk(tag, da, exp);
    chk({tag, "_resp"}, resp, exp_resp);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] da, db;
    logic [1:0]  resp;
    logic [7:0]  ea, eb;
    ea = '0;
    eb = '0;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
    end
    rd(8'h00, da, db, resp);
    chk({tag, "_msb"}, da, {24'h0, ea});
    chk({tag, "_lsb"}, db, {24'h0, eb});
    chk({tag, "_resp"}, resp, 2'b00);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int gap, output logic [1:0] resp);
    int n;
    @(negedge clk);
    sin_valid = 1'b0;
    aw_valid = 1'b1;
    aw_addr = {24'h0, addr};
    w_data = data;
    w_strb = strb;
    if (gap == 0) w_valid = 1'b1;
    n = 0;
    while (!aw_ready_a && n < 20) begin @(negedge clk); n++; end
    if (!aw_ready_a) chk("aw_ready_timeout", aw_ready_a, 1);
    @(negedge clk);
    aw_valid = 1'b0;
    w_valid = 1'b0;
    if (gap > 0) begin
      for (int i = 0; i < gap; i++) begin
        chk("b_early", b_valid_a, 0);
        @(negedge clk);
      end
      w_valid = 1'b1;
      n = 0;
      while (!w_ready_a && n < 20) begin @(negedge clk); n++; end
      if (!w_ready_a) chk("w_ready_timeout", w_ready_a, 1);
      @(negedge clk);
      w_valid = 1'b0;
    end
    b_ready = 1'b1;
    n = 0;
    while (!b_valid_a && n < 20) begin @(negedge clk); n++; end
    if (!b_valid_a) chk("b_valid_timeout", b_valid_a, 1);
    resp = b_resp_a;
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [7:0]  w;
    logic [31:0] da, db;

    rstn = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
    aw_addr = '0; w_data = '0; ar_addr = '0; aw_prot = '0; ar_prot = '0; w_strb = '0;
    repeat (3) @(negedge clk);
    chk("rst_irq", {irq_a, irq_b}, 0);
    chk("rst_bvalid", {b_valid_a, b_valid_b}, 0);
    chk("rst_rvalid", {r_valid_a, r_valid_b}, 0);
    chk("rst_ready", {aw_ready_a, w_ready_a, ar_ready_a, aw_ready_b, w_ready_b, ar_ready_b}, 6'h3f);
    chk("rst_rdata", r_data_a | r_data_b, 0);
    chk("rst_resp", {b_resp_a, r_resp_a, b_resp_b, r_resp_b}, 0);
    rstn = 1'b1;
    rd_chk("ctrl_rst", 8'h10, 32'h1, 2'b00);
    rd_chk("thresh_rst", 8'h20, 32'h1, 2'b00);
    rd_chk("status_rst", 8'h08, 32'h1, 2'b00);

    // Basic words in both bit orders
    send_bits(8'hA5, 8);
    stop_bits();
    rd_chk("level_a5", 8'h18, 32'h1, 2'b00);
    rd_data("data_a5");
    rd_chk("level_a5_after", 8'h18, 32'h0, 2'b00);
    send_bits(8'hF0, 8);
    rd_data("data_1111_0000");
    rd_data("data_empty");

    // Overflow: five words into four entries
    for (int i = 0; i < 5; i++) send_bits(8'($urandom), 8);
    stop_bits();
    rd_chk("status_ovf", 8'h08, 32'h6, 2'b00);
    rd_chk("level_full", 8'h18, 32'h4, 2'b00);
    for (int i = 0; i < 4; i++) rd_data("data_ovf");
    wr(8'h10, 32'h5, 4'hf, 0, resp);
    chk("ovf_clr_resp", resp, 2'b00);
    rd_chk("status_ovf_clr", 8'h08, 32'h1, 2'b00);

    // Full FIFO with a word completing on the pop edge
    for (int i = 0; i < 4; i++) send_bits(8'($urandom), 8);
    w = 8'($urandom);
    send_bits(w, 7);
    @(negedge clk);
    sin_valid = 1'b0;
    ar_valid = 1'b1;
    ar_addr = 32'h0;
    chk("pop_ar_ready", ar_ready_a, 1);
    @(negedge clk);
    ar_valid = 1'b0;
    r_ready = 1'b1;
    sin = w[0];
    sin_valid = 1'b1;
    da = {24'h0, qa.pop_front()};
    db = {24'h0, qb.pop_front()};
    mdl_bit(w[0]);
    @(negedge clk);
    sin_valid = 1'b0;
    chk("pop_rvalid", r_valid_a, 1);
    chk("pop_data_msb", r_data_a, da);
    chk("pop_data_lsb", r_data_b, db);
    @(negedge clk);
    r_ready = 1'b0;
    rd_chk("pop_level", 8'h18, 32'h4, 2'b00);
    rd_chk("pop_status", 8'h08, 32'h2, 2'b00);
    for (int i = 0; i < 4; i++) rd_data("data_pop_push");

    // Flush drops stored words and a partial word
    send_bits(8'($urandom), 8);
    send_bits(8'($urandom), 3);
    wr(8'h10, 32'h3, 4'h1, 0, resp);
    mdl_reset();
    chk("flush_resp", resp, 2'b00);
    rd_chk("flush_level", 8'h18, 32'h0, 2'b00);
    rd_chk("flush_ctrl", 8'h10, 32'h1, 2'b00);
    send_bits(8'($urandom), 8);
    stop_bits();
    rd_chk("flush_level2", 8'h18, 32'h1, 2'b00);
    rd_data("data_flush");

    // EN=0 freezes the deserialiser
    w = 8'($urandom);
    send_bits(w, 4);
    wr(8'h10, 32'h0, 4'h1, 0, resp);
    mdl_en = 1'b0;
    send_bits(8'($urandom), 8);
    wr(8'h10, 32'h1, 4'h1, 0, resp);
    mdl_en = 1'b1;
    rd_chk("en_level0", 8'h18, 32'h0, 2'b00);
    send_bits(w << 4, 4);
    stop_bits();
    rd_chk("en_level1", 8'h18, 32'h1, 2'b00);
    rd_data("data_en");

    // Threshold saturation, byte strobe, interrupt
    wr(8'h20, 32'h9, 4'h1, 0, resp);
    rd_chk("thresh_sat", 8'h20, 32'h4, 2'b00);
    wr(8'h20, 32'h2, 4'he, 0, resp);
    chk("strb0_resp", resp, 2'b00);
    rd_chk("thresh_strb0", 8'h20, 32'h4, 2'b00);
    wr(8'h20, 32'h2, 4'h1, 0, resp);
    wr(8'h10, 32'h9, 4'h1, 0, resp);
    rd_chk("ctrl_irq_en", 8'h10, 32'h9, 2'b00);
    send_bits(8'($urandom), 8);
    send_bits(8'($urandom), 8);
    stop_bits();
    chk("irq_lag", {irq_a, irq_b}, 2'b00);
    @(negedge clk);
    chk("irq_set", {irq_a, irq_b}, 2'b11);
    rd_chk("status_irq", 8'h08, 32'h8, 2'b00);
    rd_data("data_irq");
    chk("irq_clr", {irq_a, irq_b}, 2'b00);
    rd_chk("status_noirq", 8'h08, 32'h0, 2'b00);
    rd_data("data_irq2");
    rd_chk("unmapped_rd", 8'h28, 32'h0, 2'b10);
    wr(8'h30, 32'h1, 4'h1, 0, resp);
    chk("unmapped_wr", resp, 2'b10);
    wr(8'h04, 32'h1, 4'h1, 0, resp);
    chk("unaligned_wr", resp, 2'b10);
    wr(8'h10, 32'h1, 4'h1, 0, resp);

    // Reset mid-word
    send_bits(8'($urandom), 5);
    @(negedge clk);
    sin_valid = 1'b0;
    rstn = 1'b0;
    mdl_reset();
    @(negedge clk);
    chk("midrst_irq", {irq_a, irq_b}, 2'b00);
    rstn = 1'b1;
    rd_chk("midrst_ctrl", 8'h10, 32'h1, 2'b00);
    rd_chk("midrst_thresh", 8'h20, 32'h1, 2'b00);
    send_bits(8'($urandom), 8);
    stop_bits();
    rd_chk("midrst_level", 8'h18, 32'h1, 2'b00);
    rd_data("data_midrst");

    // AW three cycles ahead of W
    wr(8'h20, 32'h3, 4'h1, 3, resp);
    chk("gap_resp", resp, 2'b00);
    chk("gap_single_b", {b_valid_a, b_valid_b}, 2'b00);
    rd_chk("gap_thresh", 8'h20, 32'h3, 2'b00);
    rd(8'h08, da, db, resp);
    chk("lockstep_status", db, da);
    chk("lockstep_resp", {r_valid_b, r_resp_b, b_resp_b}, {r_valid_a, r_resp_a, b_resp_a});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
